serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built on the full_adder cell: one full_adder instance
//  plus a carry flop, operand shift registers and a bit counter. Sits upstream of the
//  1-bit cell, sequencing operand bits into it and collecting sum bits. Area-cheap
//  alternative to a ripple array, for control paths where latency is not critical.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk_in     in   1      rising-edge clock
//  rst_n_in   in   1      asynchronous active-low reset
//  start_in   in   1      request; sampled only in IDLE
//  a_in       in   WIDTH  operand A; captured on accepted start
//  b_in       in   WIDTH  operand B; captured on accepted start
//  c_in       in   1      carry-in; captured on accepted start
//  busy_out   out  1      high while an addition is in progress (RUN)
//  done_out   out  1      one-cycle pulse: result valid
//  sum_out    out  WIDTH  registered result; holds until the next done_out
//  carry_out  out  1      registered carry-out of the MSB; updates with sum_out
//  ovf_out    out  1      signed overflow (present only with SERIAL_ADDER_OVF_EN)
// BEHAVIOUR
//  - Reset (rst_n_in low, async): state=IDLE; busy_out=0, done_out=0, sum_out=0,
//    carry_out=0, ovf_out=0; shift regs, counter, carry flop cleared.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start_in=1 at edge k -> load a_sh=a_in, b_sh=b_in, cy=c_in, cnt=0; go RUN.
//    RUN: each edge feeds a_sh[0], b_sh[0], cy to the full_adder; cy<=carry;
//      sum bit shifted into MSB of internal s_sh; a_sh/b_sh shift right; cnt++.
//      At the edge with cnt==WIDTH-1 (edge k+WIDTH): sum_out<=final s_sh,
//      carry_out<=final carry; go DONE.
//    DONE: done_out=1 for exactly one cycle; next edge -> IDLE unconditionally.
//  - Latency: start accepted at edge k -> busy_out high during cycles k+1..k+WIDTH,
//    done_out high in the cycle after edge k+WIDTH. Throughput: one add per WIDTH+2 cycles.
//  - start_in ignored in RUN and DONE (no queuing); a_in/b_in/c_in may change freely
//    after the accepting edge.
//  - sum_out/carry_out never show partial results; they hold the previous result
//    throughout a new operation and change only on the edge that enters DONE.
//  - Arithmetic: {carry_out, sum_out} = a + b + c_in, unsigned, modulo 2^(WIDTH+1).
//  - cnt is $clog2(WIDTH) bits; terminal compare is ==WIDTH-1, no wrap beyond.
//  - Reset asserted mid-RUN/DONE aborts: outputs cleared, no done_out pulse; first
//    start after reset release behaves as a fresh operation.
//  - busy_out and done_out are never high in the same cycle.
// CONFIGURATION
//  SERIAL_ADDER_OVF_EN defined: port ovf_out exists; on the DONE-entry edge
//    ovf_out <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), held like
//    sum_out; requires one extra flop capturing cy before the MSB step.
//  SERIAL_ADDER_OVF_EN undefined: ovf_out port and its logic absent; all else identical.
// TESTING (WIDTH=8)
//  1. a=0x0F b=0x01 c=0, start 1 cycle -> busy 8 cycles, done pulse; sum=0x10 carry=0.
//  2. a=0xFF b=0x01 c=0 -> sum=0x00 carry=1, ovf=0; a=0x00 b=0x00 c=1 -> sum=0x01 carry=0.
//  3. a=0x7F b=0x01 c=0 -> sum=0x80 carry=0, ovf=1 (OVF_EN build); a=0x80 b=0x80 -> 0x00, carry=1, ovf=1.
//  4. start held high through RUN with new operands 0x11/0x22 -> first result only
//     (sum=0x10 from 0x0F+0x01); new op accepted only once back in IDLE -> 0x33.
//  5. rst_n_in low at 3rd RUN cycle -> all outputs 0 immediately, no done; after release
//     a=0xAA b=0x55 c=1 -> sum=0x00 carry=1.
//  6. Prior result 0x10 held on sum_out during entire next operation until its done edge.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, a carry flop, operand shift registers and a bit counter.
// Optional signed-overflow output ovf_out is built only when SERIAL_ADDER_OVF_EN is defined.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_out
`endif
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
    // Only WIDTH-1 sum bits are stored; the MSB comes straight from the cell on the final step.
    logic [WIDTH-2:0]   s_sh_reg, s_sh_next;
    logic               cy_reg, cy_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               carry_reg, carry_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_reg, ovf_next;
`endif

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   a_shift;
    logic [WIDTH-1:0]   b_shift;
    logic [WIDTH-2:0]   s_shift;

    full_adder u_fa (
        .a  (a_sh_reg[0]),
        .b  (b_sh_reg[0]),
        .ci (cy_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    // Right-shift networks: operands drain LSB first, sum bits enter at the top.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_op_shift
            assign a_shift[gi] = a_sh_reg[gi+1];
            assign b_shift[gi] = b_sh_reg[gi+1];
        end
        for (gi = 0; gi < WIDTH - 2; gi++) begin : g_sum_shift
            assign s_shift[gi] = s_sh_reg[gi+1];
        end
    endgenerate

    assign a_shift[WIDTH-1] = 1'b0;
    assign b_shift[WIDTH-1] = 1'b0;
    assign s_shift[WIDTH-2] = fa_s;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            cy_reg    <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            s_sh_reg  <= s_sh_next;
            cy_reg    <= cy_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        s_sh_next  = s_sh_reg;
        cy_next    = cy_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start_in) begin
                    a_sh_next  = a_in;
                    b_sh_next  = b_in;
                    cy_next    = c_in;
                    s_sh_next  = '0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next = a_shift;
                b_sh_next = b_shift;
                s_sh_next = s_shift;
                cy_next   = fa_co;
                if (cnt_reg == LAST_BIT) begin
                    // Results are published only here, so sum_out never shows partial bits.
                    sum_next   = {fa_s, s_sh_reg};
                    carry_next = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_next   = cy_reg ^ fa_co;
`endif
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_out  = (state_reg == RUN);
    assign done_out  = (state_reg == DONE);
    assign sum_out   = sum_reg;
    assign carry_out = carry_reg;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_out   = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): cycle-level behavioural model plus literal result checks.
// Handles both builds; ovf_out is checked only when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .start_in  (start),
        .a_in      (a),
        .b_in      (b),
        .c_in      (c),
        .busy_out  (busy),
        .done_out  (done),
        .sum_out   (sum),
        .carry_out (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_out   (ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {ovf, carry, sum} from plain integer addition and sign rules.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    // Model: phase 0 idle, 1..W busy, W+1 done; result becomes visible with the done cycle.
    int           m_phase;
    logic [W+1:0] m_pend;
    logic [W-1:0] m_sum;
    logic         m_carry;
    logic         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_pend  <= '0;
            m_sum   <= '0;
            m_carry <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pend  <= ref_add(a, b, c);
                m_phase <= 1;
            end
        end else if (m_phase < W) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == W) begin
            m_sum   <= m_pend[W-1:0];
            m_carry <= m_pend[W];
            m_ovf   <= m_pend[W+1];
            m_phase <= W + 1;
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("busy", 16'(busy), 16'(m_phase >= 1 && m_phase <= W));
        check("done", 16'(done), 16'(m_phase == W + 1));
        check("sum", 16'(sum), 16'(m_sum));
        check("carry", 16'(carry), 16'(m_carry));
        check("busy_and_done", 16'(busy & done), 16'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 16'(ovf), 16'(m_ovf));
`endif
    end

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(posedge clk);
        #2;
        a = av; b = bv; c = cv; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    endtask

    task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec, input logic eo,
                             input bit hold_chk, input logic [W-1:0] hold_val);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check({name, "_sum"}, 16'(sum), 16'(es));
                check({name, "_carry"}, 16'(carry), 16'(ec));
`ifdef SERIAL_ADDER_OVF_EN
                check({name, "_ovf"}, 16'(ovf), 16'(eo));
`endif
            end else if (hold_chk && busy) begin
                check({name, "_hold"}, 16'(sum), 16'(hold_val));
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout actual=no_done expected=done_pulse", name);
        end
        if (eo === 1'bx) $display("unreachable");
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 16'(busy), 16'(0));
        check("rst_sum", 16'(sum), 16'(0));
        #1 rst_n = 1'b1;

        // Basic adds and boundaries.
        launch(8'h0F, 8'h01, 1'b0); wait_done("t1", 8'h10, 1'b0, 1'b0, 0, '0);
        launch(8'hFF, 8'h01, 1'b0); wait_done("t2a", 8'h00, 1'b1, 1'b0, 0, '0);
        launch(8'h00, 8'h00, 1'b1); wait_done("t2b", 8'h01, 1'b0, 1'b0, 0, '0);
        launch(8'h7F, 8'h01, 1'b0); wait_done("t3a", 8'h80, 1'b0, 1'b1, 0, '0);
        launch(8'h80, 8'h80, 1'b0); wait_done("t3b", 8'h00, 1'b1, 1'b1, 0, '0);

        // Start held through RUN/DONE with new operands: no queuing.
        @(posedge clk);
        #2 a = 8'h0F; b = 8'h01; c = 1'b0; start = 1'b1;
        @(posedge clk);
        #2 a = 8'h11; b = 8'h22;
        wait_done("t4a", 8'h10, 1'b0, 1'b0, 0, '0);
        @(posedge clk);
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("t4b", 8'h33, 1'b0, 1'b0, 0, '0);

        // Previous result held through the whole next operation.
        launch(8'h0F, 8'h01, 1'b0); wait_done("t6a", 8'h10, 1'b0, 1'b0, 0, '0);
        launch(8'h01, 8'h02, 1'b0); wait_done("t6b", 8'h03, 1'b0, 1'b0, 1, 8'h10);

        // Reset in the third RUN cycle aborts the operation.
        launch(8'h3C, 8'h0F, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("t5_busy_pre", 16'(busy), 16'(1));
        rst_n = 1'b0;
        #1;
        check("t5_busy", 16'(busy), 16'(0));
        check("t5_done", 16'(done), 16'(0));
        check("t5_sum", 16'(sum), 16'(0));
        check("t5_carry", 16'(carry), 16'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        launch(8'hAA, 8'h55, 1'b1); wait_done("t5b", 8'h00, 1'b1, 1'b0, 0, '0);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
